// File: rtl/mem_bridge.sv
// mem_bridge: single-outstanding CPU-to-RAM bridge with alignment check and ack timeout
module mem_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_ready_o,
  output logic        cpu_err_o,
  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  input  logic        ram_ack_i,
  output logic [15:0] txn_count_o
);
  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;
  state_t state, state_n;
  logic [W-1:0] wait_cnt;
  logic start;
  always_comb begin
    start = state == IDLE && cpu_req_i;
    state_n = state;
    case (state)
      IDLE: state_n = !cpu_req_i ? IDLE : (cpu_addr_i[1:0] != 2'b00) ? ERR : BUSY;
      BUSY: state_n = ram_ack_i ? DONE : (wait_cnt == LAST) ? ERR : BUSY;
      default: state_n = IDLE;
    endcase
  end
  // Every output is loaded from the next state so it is registered yet aligned with the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      wait_cnt <= '0;
      cpu_rdata_o <= '0;
      cpu_ready_o <= 1'b0;
      cpu_err_o <= 1'b0;
      ram_req_o <= 1'b0;
      ram_we_o <= 1'b0;
      ram_addr_o <= '0;
      ram_wdata_o <= '0;
      txn_count_o <= '0;
    end else begin
      state <= state_n;
      wait_cnt <= (state == BUSY && !ram_ack_i) ? wait_cnt + 1'b1 : '0;
      ram_req_o <= state_n == BUSY;
      ram_we_o <= state_n == BUSY && (start ? cpu_we_i : ram_we_o);
      cpu_ready_o <= state_n == DONE || state_n == ERR;
      cpu_err_o <= state_n == ERR;
      if (start) begin
        ram_addr_o <= {cpu_addr_i[31:2], 2'b00};
        ram_wdata_o <= cpu_wdata_i;
      end
      if (state == BUSY && ram_ack_i && !ram_we_o)
        cpu_rdata_o <= ram_rdata_i;
      if (state_n == DONE)
        txn_count_o <= txn_count_o + 16'd1;
    end
  end
endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: randomized transactions checked every cycle against a timeline model
module tb_mem_bridge;
  localparam int TIMEOUT = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cpu_req_i = 1'b0;
  logic cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_wdata_i = '0;
  logic [31:0] cpu_rdata_o;
  logic cpu_ready_o;
  logic cpu_err_o;
  logic ram_req_o;
  logic ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i = '0;
  logic ram_ack_i = 1'b0;
  logic [15:0] txn_count_o;
  always #5 clk = ~clk;
  mem_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .reset(reset),
    .cpu_req_i(cpu_req_i),
    .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i),
    .cpu_rdata_o(cpu_rdata_o),
    .cpu_ready_o(cpu_ready_o),
    .cpu_err_o(cpu_err_o),
    .ram_req_o(ram_req_o),
    .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i),
    .ram_ack_i(ram_ack_i),
    .txn_count_o(txn_count_o)
  );
  int checks = 0;
  int passes = 0;
  logic chk_on = 1'b0;
  logic exp_req, exp_we, exp_ready, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [15:0] exp_cnt;
  int hi_cnt;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp)
      passes++;
    else
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  always @(negedge clk) begin
    if (chk_on) begin
      check("ram_req", 32'(ram_req_o), 32'(exp_req));
      check("cpu_ready", 32'(cpu_ready_o), 32'(exp_ready));
      check("cpu_err", 32'(cpu_err_o), 32'(exp_err));
      check("cpu_rdata", cpu_rdata_o, exp_rdata);
      check("txn_count", 32'(txn_count_o), 32'(exp_cnt));
      if (exp_req) begin
        check("ram_we", 32'(ram_we_o), 32'(exp_we));
        check("ram_addr", ram_addr_o, exp_addr);
        check("ram_wdata", ram_wdata_o, exp_wdata);
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic model_clear;
    exp_req = 0;
    exp_we = 0;
    exp_ready = 0;
    exp_err = 0;
    exp_addr = '0;
    exp_wdata = '0;
    exp_rdata = '0;
    exp_cnt = '0;
  endtask
  // d = BUSY cycle in which ack is raised; 0 means never.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int d, input logic [31:0] rd_val);
    logic done;
    cpu_req_i = 1;
    cpu_we_i = we;
    cpu_addr_i = addr;
    cpu_wdata_i = wdata;
    ram_ack_i = 1'($urandom);
    tick;
    hi_cnt = int'(ram_req_o);
    cpu_req_i = 1'($urandom);
    cpu_we_i = 1'($urandom);
    cpu_addr_i = $urandom;
    cpu_wdata_i = $urandom;
    if (addr[1:0] != 2'b00) begin
      exp_req = 0;
      exp_ready = 1;
      exp_err = 1;
    end else begin
      exp_req = 1;
      exp_we = we;
      exp_addr = {addr[31:2], 2'b00};
      exp_wdata = wdata;
      done = 0;
      for (int k = 1; !done; k++) begin
        ram_ack_i = (k == d);
        ram_rdata_i = (k == d) ? rd_val : $urandom;
        tick;
        hi_cnt += int'(ram_req_o);
        if (k == d) begin
          exp_req = 0;
          exp_ready = 1;
          exp_err = 0;
          exp_cnt = exp_cnt + 16'd1;
          if (!we) exp_rdata = rd_val;
          done = 1;
        end else if (k == TIMEOUT) begin
          exp_req = 0;
          exp_ready = 1;
          exp_err = 1;
          done = 1;
        end
      end
    end
    cpu_req_i = 0;
    ram_ack_i = 1'($urandom);
    ram_rdata_i = $urandom;
    tick;
    exp_ready = 0;
    exp_err = 0;
    ram_ack_i = 0;
  endtask
  initial begin
    model_clear();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      cpu_req_i = 1'($urandom);
      cpu_addr_i = $urandom;
      cpu_we_i = 1'($urandom);
      ram_ack_i = 1'($urandom);
      tick;
      chk_on = 1;
    end
    check("rst_ram_addr", ram_addr_o, 32'h0);
    check("rst_ram_wdata", ram_wdata_o, 32'h0);
    check("rst_ram_we", 32'(ram_we_o), 32'h0);
    reset = 1;
    ram_ack_i = 0;
    run_txn(0, 32'h0000_0010, 32'h0, 1, 32'hCAFE_F00D);
    check("read_hi_cycles", 32'(hi_cnt), 32'd1);
    check("read_rdata", cpu_rdata_o, 32'hCAFE_F00D);
    check("read_count", 32'(txn_count_o), 32'd1);
    run_txn(1, 32'h0000_0020, 32'h1234_5678, 5, 32'hDEAD_BEEF);
    check("write_hi_cycles", 32'(hi_cnt), 32'd5);
    check("write_rdata_kept", cpu_rdata_o, 32'hCAFE_F00D);
    check("write_count", 32'(txn_count_o), 32'd2);
    run_txn(0, 32'h0000_0013, 32'h0, 1, 32'h0);
    check("misalign_hi_cycles", 32'(hi_cnt), 32'd0);
    check("misalign_count", 32'(txn_count_o), 32'd2);
    run_txn(0, 32'h0000_0100, 32'h0, 0, 32'h0);
    check("timeout_hi_cycles", 32'(hi_cnt), 32'd16);
    check("timeout_count", 32'(txn_count_o), 32'd2);
    run_txn(0, 32'h0000_0104, 32'h0, 16, 32'h0BAD_CAFE);
    check("late_ack_hi_cycles", 32'(hi_cnt), 32'd16);
    check("late_ack_rdata", cpu_rdata_o, 32'h0BAD_CAFE);
    check("late_ack_count", 32'(txn_count_o), 32'd3);
    cpu_req_i = 1;
    cpu_we_i = 1;
    cpu_addr_i = 32'h0000_0040;
    cpu_wdata_i = 32'hA5A5_5A5A;
    tick;
    cpu_req_i = 0;
    exp_req = 1;
    exp_we = 1;
    exp_addr = 32'h0000_0040;
    exp_wdata = 32'hA5A5_5A5A;
    tick;
    tick;
    reset = 0;
    tick;
    model_clear();
    check("midrst_req", 32'(ram_req_o), 32'h0);
    check("midrst_addr", ram_addr_o, 32'h0);
    check("midrst_count", 32'(txn_count_o), 32'h0);
    reset = 1;
    ram_ack_i = 1;
    tick;
    ram_ack_i = 0;
    check("late_ack_ignored", 32'(cpu_ready_o), 32'h0);
    tick;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_txn(1'($urandom), a, $urandom, $urandom_range(0, 20), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
          ram_ack_i = 1'($urandom);
          ram_rdata_i = $urandom;
          tick;
        end
        ram_ack_i = 0;
      end
    end
    force dut.txn_count_o = 16'hFFFF;
    #1;
    release dut.txn_count_o;
    exp_cnt = 16'hFFFF;
    check("preload_count", 32'(txn_count_o), 32'h0000_FFFF);
    run_txn(0, 32'h0000_0200, 32'h0, 2, 32'h7777_1111);
    check("wrap_count", 32'(txn_count_o), 32'h0);
    chk_on = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 16, maximum BUSY cycles waited for ram_ack_i before aborting; legal range 2..256.
REQ-002 clk  input  1  single clock, all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 cpu_req_i  input  1  CPU requests a memory transaction; sampled only in IDLE.
REQ-005 cpu_we_i  input  1  1 = write, 0 = read; captured with cpu_req_i.
REQ-006 cpu_addr_i  input  32  byte address; captured with cpu_req_i.
REQ-007 cpu_wdata_i  input  32  write data; captured with cpu_req_i.
REQ-008 cpu_rdata_o  output  32  read data returned to CPU.
REQ-009 cpu_ready_o  output  1  one-cycle pulse: transaction complete.
REQ-010 cpu_err_o  output  1  qualifies cpu_ready_o: transaction failed.
REQ-011 ram_req_o  output  1  request to RAM; high throughout BUSY.
REQ-012 ram_we_o  output  1  write strobe to RAM, valid while ram_req_o=1.
REQ-013 ram_addr_o  output  32  word-aligned address to RAM.
REQ-014 ram_wdata_o  output  32  write data to RAM.
REQ-015 ram_rdata_i  input  32  RAM read data, valid when ram_ack_i=1.
REQ-016 ram_ack_i  input  1  RAM completion, one or more cycles after ram_req_o rises.
REQ-017 txn_count_o  output  16  count of successfully completed transactions.

Function
REQ-018 The block SHALL implement a four-state FSM: IDLE, BUSY, DONE, ERR.
REQ-019 In IDLE with cpu_req_i=1, it SHALL capture cpu_we_i, cpu_addr_i and cpu_wdata_i, then go to ERR if cpu_addr_i[1:0]!=0, otherwise to BUSY.
REQ-020 A misaligned request SHALL never assert ram_req_o.
REQ-021 In BUSY, ram_req_o SHALL be 1, and ram_we_o, ram_addr_o and ram_wdata_o SHALL hold the captured values, stable, until BUSY exits.
REQ-022 A wait counter SHALL clear on BUSY entry and increment once per BUSY cycle without ram_ack_i.
REQ-023 In BUSY with ram_ack_i=1, the FSM SHALL go to DONE; for reads, cpu_rdata_o SHALL load ram_rdata_i on that edge.
REQ-024 In BUSY, if the wait counter equals TIMEOUT-1 and ram_ack_i=0, the FSM SHALL go to ERR.
REQ-025 If ram_ack_i=1 arrives in that same cycle, ack SHALL take priority and the FSM SHALL go to DONE.
REQ-026 DONE SHALL last one cycle with cpu_ready_o=1 and cpu_err_o=0, increment txn_count_o, then return to IDLE.
REQ-027 ERR SHALL last one cycle with cpu_ready_o=1 and cpu_err_o=1, leave cpu_rdata_o and txn_count_o unchanged, then return to IDLE.
REQ-028 Writes SHALL leave cpu_rdata_o unchanged.
REQ-029 txn_count_o SHALL wrap from 16'hFFFF to 0.
REQ-030 Minimum latency SHALL be: request sampled at edge N, ram_req_o high from N+1; ack at N+1 gives cpu_ready_o at N+2.
REQ-031 Back-to-back transactions SHALL start no sooner than the IDLE cycle following DONE/ERR.
REQ-032 A cpu_req_i still high in that IDLE cycle SHALL start a new transaction.
REQ-033 cpu_req_i outside IDLE, and ram_ack_i outside BUSY, SHALL be ignored.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 With reset=0 at a rising edge, the FSM SHALL enter IDLE and all outputs and internal registers SHALL be 0.
REQ-036 Reset asserted mid-transaction SHALL drop ram_req_o on the next edge with no cpu_ready_o pulse; a late ram_ack_i SHALL then be ignored.
REQ-037 The first request SHALL be sampled on the first edge with reset=1.

Verification
REQ-038 Read, addr=32'h0000_0010, ack one cycle after ram_req_o rises, ram_rdata_i=32'hCAFE_F00D -> cpu_ready_o=1, cpu_err_o=0, cpu_rdata_o=32'hCAFE_F00D, txn_count_o=1.
REQ-039 Write, addr=32'h0000_0020, wdata=32'h1234_5678, ack after 5 cycles -> ram_we_o=1 and ram_wdata_o stable for all 5 BUSY cycles; cpu_rdata_o unchanged; one ready pulse.
REQ-040 Read, addr=32'h0000_0013 -> ERR after one cycle with cpu_err_o=1; ram_req_o never high; txn_count_o unchanged.
REQ-041 No ack, TIMEOUT=16 -> ram_req_o high exactly 16 cycles, then cpu_ready_o=1 and cpu_err_o=1; ack arriving in the 16th BUSY cycle instead -> DONE.
REQ-042 reset=0 during the third BUSY cycle -> next edge all outputs 0; an ack one cycle later produces no ready pulse.
REQ-043 Preload txn_count_o to 16'hFFFF via 65535 transactions (or force), complete one more -> txn_count_o=0.
